// File: rtl/sum_bcd_display.sv
// sum_bcd_display: display stage for the 4-bit adder result.
//   Captures a DATA_W-bit binary value on load, converts it to two BCD digits
//   with a sequential shift-add-3 (double-dabble) FSM, then time-multiplexes
//   both digits onto a 2-digit common-anode 7-segment display.
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset
//   load, value : start conversion / binary input (sampled on accepted load)
//   busy        : conversion in progress
//   bcd         : registered result, [7:4] tens, [3:0] units
//   seg_n, dp_n : active-low segments (g..a) and decimal point
//   an_n        : active-low one-hot digit enables, [0] units, [1] tens
module sum_bcd_display #(
  parameter int DATA_W      = 5,
  parameter int REFRESH_DIV = 50000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] value,
  output logic              busy,
  output logic [7:0]        bcd,
  output logic [6:0]        seg_n,
  output logic              dp_n,
  output logic [1:0]        an_n
);

  localparam int CW = (DATA_W < 2) ? 1 : $clog2(DATA_W);
  localparam int RW = $clog2(REFRESH_DIV);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic [7:0]        scr_q, scr_d, scr_adj;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [7:0]        bcd_q, bcd_d;
  logic [RW-1:0]     rcnt_q;
  logic              sel_q;
  logic [3:0]        nib;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // Add-3 correction applied to each scratch nibble before the shift.
  always_comb begin
    scr_adj[7:4] = (scr_q[7:4] >= 4'd5) ? scr_q[7:4] + 4'd3 : scr_q[7:4];
    scr_adj[3:0] = (scr_q[3:0] >= 4'd5) ? scr_q[3:0] + 4'd3 : scr_q[3:0];
  end

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    scr_d   = scr_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    case (state_q)
      IDLE: if (load) begin
        sh_d    = value;
        scr_d   = '0;
        cnt_d   = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        {scr_d, sh_d} = {scr_adj, sh_q} << 1;
        cnt_d         = cnt_q + CW'(1);
        if (cnt_q == CW'(DATA_W - 1)) state_d = DONE;
      end
      DONE: begin
        // bcd only changes here, so the display never sees partial results
        bcd_d   = scr_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sh_q    <= '0;
      scr_q   <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      scr_q   <= scr_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
    end
  end

  // Free-running refresh divider, independent of the conversion FSM.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rcnt_q <= '0;
      sel_q  <= 1'b0;
    end else if (rcnt_q == RW'(REFRESH_DIV - 1)) begin
      rcnt_q <= '0;
      sel_q  <= ~sel_q;
    end else begin
      rcnt_q <= rcnt_q + RW'(1);
    end
  end

  always_comb begin
    nib   = sel_q ? bcd_q[7:4] : bcd_q[3:0];
    an_n  = sel_q ? 2'b01 : 2'b10;
    // Leading-zero blanking on the tens digit only; anode stays driven.
    seg_n = (sel_q && bcd_q[7:4] == 4'd0) ? 7'b1111111 : seg7(nib);
  end

  assign busy = (state_q != IDLE);
  assign bcd  = bcd_q;
  assign dp_n = 1'b1;

endmodule

// File: tb/tb_sum_bcd_display.sv
// tb_sum_bcd_display: self-checking bench for sum_bcd_display (REFRESH_DIV=4).
module tb_sum_bcd_display;

  localparam int DW  = 5;
  localparam int DIV = 4;
  localparam logic [6:0] SEGTAB [10] = '{7'b1000000, 7'b1111001, 7'b0100100,
    7'b0110000, 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000,
    7'b0010000};

  logic          clk, rst_n, load;
  logic [DW-1:0] value;
  logic          busy, dp_n;
  logic [7:0]    bcd;
  logic [6:0]    seg_n;
  logic [1:0]    an_n;

  int total = 0;
  int bad   = 0;
  int k     = 0;   // clock edges since reset release
  int exp_val = 0; // decimal value the display should show

  sum_bcd_display #(.DATA_W(DW), .REFRESH_DIV(DIV)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .value(value), .busy(busy),
    .bcd(bcd), .seg_n(seg_n), .dp_n(dp_n), .an_n(an_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst_n) k <= 0;
    else        k <= k + 1;
  end

  function automatic logic [7:0] exp_bcd(input int v);
    return 8'((v / 10) * 16 + (v % 10));
  endfunction

  function automatic bit exp_sel();
    return ((k / DIV) % 2) == 1;
  endfunction

  function automatic logic [1:0] exp_an();
    return exp_sel() ? 2'b01 : 2'b10;
  endfunction

  function automatic logic [6:0] exp_seg(input int v);
    int t, u;
    t = v / 10;
    u = v % 10;
    if (exp_sel() && t == 0) return 7'b1111111;
    return exp_sel() ? SEGTAB[t] : SEGTAB[u];
  endfunction

  task automatic start_load(input int v);
    load  = 1'b1;
    value = DW'(v);
    @(negedge clk);
    load  = 1'b0;
    value = DW'($urandom);
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy === 1'b1 && n < 20) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; load = 1'b1; value = DW'(27);
    repeat (2) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (bcd !== 8'h00) begin bad++; $display("FAIL reset_bcd: got %h want 00", bcd); end
    total++; if (an_n !== 2'b10) begin bad++; $display("FAIL reset_an: got %b want 10", an_n); end
    total++; if (seg_n !== 7'b1000000) begin bad++; $display("FAIL reset_seg: got %b want 1000000", seg_n); end
    total++; if (dp_n !== 1'b1) begin bad++; $display("FAIL reset_dp: got %b want 1", dp_n); end
    rst_n = 1'b1; load = 1'b0;
    exp_val = 0;
  endtask

  task automatic test_convert();
    int n;
    start_load(27);
    wait_idle(n);
    exp_val = 27;
    total++; if (n != DW + 1) begin bad++; $display("FAIL conv_busy_len: got %0d want %0d", n, DW + 1); end
    total++; if (bcd !== 8'h27) begin bad++; $display("FAIL conv_bcd: got %h want 27", bcd); end
    for (int j = 0; j < 10; j++) begin
      total++; if (an_n !== exp_an()) begin bad++; $display("FAIL conv_an: got %b want %b", an_n, exp_an()); end
      total++; if (seg_n !== exp_seg(exp_val)) begin bad++; $display("FAIL conv_seg: got %b want %b", seg_n, exp_seg(exp_val)); end
      total++; if (dp_n !== 1'b1) begin bad++; $display("FAIL conv_dp: got %b want 1", dp_n); end
      @(negedge clk);
    end
  endtask

  task automatic test_blank();
    int n;
    start_load(9);
    wait_idle(n);
    exp_val = 9;
    total++; if (n != DW + 1) begin bad++; $display("FAIL blank_busy_len: got %0d want %0d", n, DW + 1); end
    total++; if (bcd !== 8'h09) begin bad++; $display("FAIL blank_bcd: got %h want 09", bcd); end
    for (int j = 0; j < 10; j++) begin
      total++; if (an_n !== exp_an()) begin bad++; $display("FAIL blank_an: got %b want %b", an_n, exp_an()); end
      total++; if (seg_n !== exp_seg(exp_val)) begin bad++; $display("FAIL blank_seg: got %b want %b", seg_n, exp_seg(exp_val)); end
      @(negedge clk);
    end
  endtask

  task automatic test_random();
    int n, v;
    for (int i = 0; i < 16; i++) begin
      v = $urandom_range(0, 31);
      start_load(v);
      n = 0;
      while (busy === 1'b1 && n < 20) begin
        total++; if (bcd !== exp_bcd(exp_val)) begin bad++; $display("FAIL rand_hold: got %h want %h", bcd, exp_bcd(exp_val)); end
        n++;
        @(negedge clk);
      end
      exp_val = v;
      total++; if (n != DW + 1) begin bad++; $display("FAIL rand_busy_len: v=%0d got %0d want %0d", v, n, DW + 1); end
      total++; if (bcd !== exp_bcd(v)) begin bad++; $display("FAIL rand_bcd: v=%0d got %h want %h", v, bcd, exp_bcd(v)); end
      repeat (2) begin
        total++; if (seg_n !== exp_seg(exp_val)) begin bad++; $display("FAIL rand_seg: v=%0d got %b want %b", v, seg_n, exp_seg(exp_val)); end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_lockout();
    int n;
    start_load(31);
    n = 0;
    while (busy === 1'b1 && n < 20) begin
      n++;
      if (n == 3) begin load = 1'b1; value = DW'(12); end
      else begin load = 1'b0; value = DW'($urandom); end
      @(negedge clk);
    end
    load = 1'b0;
    exp_val = 31;
    total++; if (n != DW + 1) begin bad++; $display("FAIL lock_busy_len: got %0d want %0d", n, DW + 1); end
    total++; if (bcd !== 8'h31) begin bad++; $display("FAIL lock_bcd: got %h want 31", bcd); end
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL lock_not_queued: got %b want 0", busy); end
    start_load(0);
    wait_idle(n);
    exp_val = 0;
    total++; if (bcd !== 8'h00) begin bad++; $display("FAIL lock_zero_bcd: got %h want 00", bcd); end
    for (int j = 0; j < 8; j++) begin
      total++; if (seg_n !== exp_seg(0)) begin bad++; $display("FAIL lock_zero_seg: got %b want %b", seg_n, exp_seg(0)); end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    load = 1'b1; value = DW'(14);
    @(negedge clk);
    value = DW'(5);
    n = 0;
    while (busy === 1'b1 && n < 20) begin n++; @(negedge clk); end
    total++; if (n != DW + 1) begin bad++; $display("FAIL b2b_first_len: got %0d want %0d", n, DW + 1); end
    total++; if (bcd !== 8'h14) begin bad++; $display("FAIL b2b_first_bcd: got %h want 14", bcd); end
    @(negedge clk);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_accept: got %b want 1", busy); end
    load = 1'b0;
    wait_idle(n);
    exp_val = 5;
    total++; if (n != DW + 1) begin bad++; $display("FAIL b2b_second_len: got %0d want %0d", n, DW + 1); end
    total++; if (bcd !== 8'h05) begin bad++; $display("FAIL b2b_second_bcd: got %h want 05", bcd); end
  endtask

  task automatic test_reset_mid();
    int n;
    start_load(20);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_val = 0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy: got %b want 0", busy); end
    total++; if (bcd !== 8'h00) begin bad++; $display("FAIL mid_bcd: got %h want 00", bcd); end
    total++; if (an_n !== 2'b10) begin bad++; $display("FAIL mid_an: got %b want 10", an_n); end
    start_load(20);
    wait_idle(n);
    exp_val = 20;
    total++; if (n != DW + 1) begin bad++; $display("FAIL mid_reload_len: got %0d want %0d", n, DW + 1); end
    total++; if (bcd !== 8'h20) begin bad++; $display("FAIL mid_reload_bcd: got %h want 20", bcd); end
  endtask

  task automatic test_refresh();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_val = 0;
    for (int j = 0; j < 24; j++) begin
      // j counts edges since release: digits swap every DIV edges
      total++; if (an_n !== (((j / DIV) % 2) ? 2'b01 : 2'b10)) begin bad++; $display("FAIL refresh_an: j=%0d got %b", j, an_n); end
      total++; if (seg_n !== exp_seg(0)) begin bad++; $display("FAIL refresh_seg: j=%0d got %b want %b", j, seg_n, exp_seg(0)); end
      @(negedge clk);
    end
  endtask

  initial begin
    rst_n = 1'b0; load = 1'b0; value = '0;
    test_reset();
    test_convert();
    test_blank();
    test_random();
    test_lockout();
    test_back_to_back();
    test_reset_mid();
    test_refresh();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
